// File: rtl/i2c_reg_master.sv
// I2C register-access master: START, device/register pointer, N data bytes
// (write, or repeated-start read), STOP. Open-drain outputs, clock stretching, timeout.
module i2c_reg_master #(
  parameter int CLK_DIV     = 4,
  parameter int LEN_W       = 4,
  parameter int STRETCH_MAX = 255
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             rw,
  input  logic [6:0]       dev_addr,
  input  logic [7:0]       reg_addr,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       wr_data,
  output logic             wr_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic             nack_err,
  output logic             timeout_err,
  output logic             scl_oe,
  output logic             sda_oe,
  input  logic             scl_i,
  input  logic             sda_i
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW = (STRETCH_MAX > 0) ? $clog2(STRETCH_MAX + 1) : 1;

  localparam logic [3:0] IDLE    = 4'd0,  START   = 4'd1,  DEV_W   = 4'd2,
                         ACK_DW  = 4'd3,  REG     = 4'd4,  ACK_REG = 4'd5,
                         WDATA   = 4'd6,  ACK_WD  = 4'd7,  RESTART = 4'd8,
                         DEV_R   = 4'd9,  ACK_DR  = 4'd10, RDATA   = 4'd11,
                         MACK    = 4'd12, STOP    = 4'd13;

  logic [3:0]       state;
  logic [2:0]       q, bit_idx;
  logic [DW-1:0]    div;
  logic [SW-1:0]    stretch;
  logic [7:0]       sh, rx, reg_r;
  logic [6:0]       dev_r;
  logic             rw_r, ack_bit;
  logic [LEN_W-1:0] cnt;

  logic waiting, q_end, bit_end, sample, tx_bit, accept, cnt_last;
  logic [2:0] last_q;

  always_comb begin
    waiting  = (state != IDLE) && (q == 3'd2) && !scl_i;
    q_end    = (state != IDLE) && !waiting && (div == DW'(CLK_DIV - 1));
    // STOP spans two bit times: the stop condition plus the bus-free interval
    last_q   = (state == STOP) ? 3'd7 : 3'd3;
    bit_end  = q_end && (q == last_q);
    sample   = q_end && (q == 3'd2);
    tx_bit   = (state == WDATA && wr_ready) ? wr_data[7] : sh[7];
    accept   = start && (state == IDLE) && !done;
    cnt_last = (cnt == LEN_W'(1));
  end

  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    case (state)
      IDLE:    ;
      START:   sda_oe = q[1];
      RESTART: begin scl_oe = !q[1]; sda_oe = (q == 3'd3); end
      STOP:    begin scl_oe = (q < 3'd2); sda_oe = (q == 3'd1) || (q == 3'd2); end
      DEV_W, REG, WDATA, DEV_R: begin scl_oe = !q[1]; sda_oe = !tx_bit; end
      MACK:    begin scl_oe = !q[1]; sda_oe = !cnt_last; end
      default: scl_oe = !q[1];
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;       q <= '0;          div <= '0;      stretch <= '0;
      bit_idx <= 3'd7;     sh <= '0;         rx <= '0;       reg_r <= '0;
      dev_r <= '0;         rw_r <= 1'b0;     ack_bit <= 1'b0; cnt <= '0;
      wr_ready <= 1'b0;    rd_data <= '0;    rd_valid <= 1'b0;
      busy <= 1'b0;        done <= 1'b0;     nack_err <= 1'b0; timeout_err <= 1'b0;
    end else begin
      done     <= 1'b0;
      wr_ready <= 1'b0;
      rd_valid <= 1'b0;
      if (state == IDLE) begin
        q <= '0; div <= '0; stretch <= '0; bit_idx <= 3'd7;
        if (accept) begin
          state <= START;   busy <= 1'b1;
          nack_err <= 1'b0; timeout_err <= 1'b0;
          rw_r <= rw; dev_r <= dev_addr; reg_r <= reg_addr; cnt <= len;
        end
      end else if (waiting && stretch == SW'(STRETCH_MAX)) begin
        state <= IDLE; busy <= 1'b0; done <= 1'b1; timeout_err <= 1'b1;
      end else begin
        if (waiting) begin
          div <= '0; stretch <= stretch + 1'b1;
        end else begin
          stretch <= '0;
          div <= q_end ? '0 : div + 1'b1;
        end
        if (q_end) q <= bit_end ? 3'd0 : q + 3'd1;
        if (wr_ready) sh <= wr_data;
        if (sample) begin
          rx <= {rx[6:0], sda_i};
          ack_bit <= sda_i;
        end
        if (bit_end) begin
          case (state)
            START: begin state <= DEV_W; sh <= {dev_r, 1'b0}; end
            DEV_W, REG, WDATA, DEV_R: begin
              bit_idx <= bit_idx - 3'd1;
              sh <= {sh[6:0], 1'b0};
              if (bit_idx == 3'd0) begin
                case (state)
                  DEV_W:   state <= ACK_DW;
                  REG:     state <= ACK_REG;
                  WDATA:   state <= ACK_WD;
                  default: state <= ACK_DR;
                endcase
              end
            end
            RDATA: begin
              bit_idx <= bit_idx - 3'd1;
              if (bit_idx == 3'd0) begin
                state <= MACK; rd_valid <= 1'b1; rd_data <= rx;
              end
            end
            ACK_DW:
              if (ack_bit) begin nack_err <= 1'b1; state <= STOP; end
              else begin state <= REG; sh <= reg_r; end
            ACK_REG:
              if (ack_bit) begin nack_err <= 1'b1; state <= STOP; end
              else if (cnt == '0) state <= STOP;
              else if (rw_r) state <= RESTART;
              else begin state <= WDATA; wr_ready <= 1'b1; end
            ACK_WD:
              if (ack_bit) begin nack_err <= 1'b1; state <= STOP; end
              else begin
                cnt <= cnt - 1'b1;
                if (cnt_last) state <= STOP;
                else begin state <= WDATA; wr_ready <= 1'b1; end
              end
            RESTART: begin state <= DEV_R; sh <= {dev_r, 1'b1}; end
            ACK_DR:
              if (ack_bit) begin nack_err <= 1'b1; state <= STOP; end
              else state <= RDATA;
            MACK: begin
              cnt <= cnt - 1'b1;
              state <= cnt_last ? STOP : RDATA;
            end
            STOP: begin state <= IDLE; busy <= 1'b0; done <= 1'b1; end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_reg_master.sv
// Scoreboard bench for i2c_reg_master: a worker model at 0x68 decodes the bus into
// frames ({ack,byte}, S=1000, P=1001) and a monitor checks them against queued expectations.
module tb_i2c_reg_master;
  logic       clock = 1'b0;
  logic       reset_n, start, rw;
  logic [6:0] dev_addr;
  logic [7:0] reg_addr, wr_data, rd_data;
  logic [3:0] len;
  logic       wr_ready, rd_valid, busy, done, nack_err, timeout_err;
  logic       scl_oe, sda_oe, scl_i, sda_i;
  logic       w_scl_hold, w_sda_low;

  assign scl_i = ~(scl_oe | w_scl_hold);
  assign sda_i = ~(sda_oe | w_sda_low);

  always #5 clock = ~clock;

  i2c_reg_master #(.CLK_DIV(4), .LEN_W(4), .STRETCH_MAX(255)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .rw(rw),
    .dev_addr(dev_addr), .reg_addr(reg_addr), .len(len), .wr_data(wr_data),
    .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .done(done), .nack_err(nack_err), .timeout_err(timeout_err),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .scl_i(scl_i), .sda_i(sda_i));

  int n_tests = 0, n_fail = 0;
  int exp_bus[$];
  logic [7:0] exp_rd[$];
  logic [1:0] exp_done[$];   // {nack_err, timeout_err}
  logic [7:0] tx_q[$];
  logic [7:0] rd_src[$];
  int wr_cnt = 0, rd_cnt = 0, done_cnt = 0;
  int abort_req = 0;
  int st_frame = -1, st_bit = 0, st_len = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_event(input int ev);
    if (exp_bus.size() == 0) check("bus_extra", ev, 32'h3ff);
    else check("bus_event", ev, exp_bus.pop_front());
  endtask

  // write-data driver
  initial begin
    wr_data = 8'h00;
    forever begin
      @(negedge clock);
      if (wr_ready) begin
        wr_cnt++;
        if (tx_q.size() == 0) check("wr_ready_extra", wr_ready, 0);
        else wr_data = tx_q.pop_front();
      end
    end
  end

  // output monitor
  initial begin
    logic [1:0] e;
    forever begin
      @(negedge clock);
      if (rd_valid) begin
        rd_cnt++;
        if (exp_rd.size() == 0) check("rd_valid_extra", rd_valid, 0);
        else check("rd_data", rd_data, exp_rd.pop_front());
      end
      if (done) begin
        done_cnt++;
        if (exp_done.size() == 0) check("done_extra", done, 0);
        else begin
          e = exp_done.pop_front();
          check("done_nack", nack_err, e[1]);
          check("done_timeout", timeout_err, e[0]);
          check("done_busy", busy, 0);
        end
      end
    end
  end

  // worker model and bus decoder
  initial begin : worker
    logic ps, pd, s, d, ackb, addressed, is_read, mnack;
    logic [7:0] byte_v, cur;
    int bitcnt, frame_no, skip, seen_abort, hold;
    w_scl_hold = 1'b0; w_sda_low = 1'b0;
    ps = 1'b1; pd = 1'b1; ackb = 1'b0; addressed = 1'b0; is_read = 1'b0; mnack = 1'b0;
    byte_v = '0; cur = '0; bitcnt = 0; frame_no = 0; skip = 0; seen_abort = 0; hold = 0;
    forever begin
      @(negedge clock);
      if (abort_req != seen_abort) begin
        seen_abort = abort_req;
        w_sda_low = 1'b0; w_scl_hold = 1'b0; hold = 0; bitcnt = 0; frame_no = 0;
        addressed = 1'b0; is_read = 1'b0; mnack = 1'b0; skip = 2;
      end
      s = scl_i; d = sda_i;
      if (skip > 0) skip--;
      else begin
        if (hold > 0) begin
          hold--;
          if (hold == 0) w_scl_hold = 1'b0;
        end
        if (ps && s && pd && !d) begin
          bus_event(1000); bitcnt = 0; frame_no = 0; mnack = 1'b0; w_sda_low = 1'b0;
        end else if (ps && s && !pd && d) begin
          bus_event(1001); bitcnt = 0; addressed = 1'b0; is_read = 1'b0; w_sda_low = 1'b0;
        end else if (!ps && s) begin
          if (bitcnt < 8) byte_v = {byte_v[6:0], d};
          else ackb = d;
          bitcnt++;
          if (bitcnt == 9) begin
            bus_event(int'({ackb, byte_v}));
            if (is_read && frame_no >= 1) mnack = ackb;
            frame_no++;
            bitcnt = 0;
          end
        end else if (ps && !s) begin
          if (st_len > 0 && frame_no == st_frame && bitcnt == st_bit) begin
            w_scl_hold = 1'b1; hold = st_len;
          end
          if (bitcnt == 8) begin
            if (frame_no == 0) begin
              addressed = (byte_v[7:1] == 7'h68);
              is_read = byte_v[0];
              w_sda_low = addressed;
            end else w_sda_low = addressed && !is_read;
          end else if (is_read && addressed && frame_no >= 1 && !mnack) begin
            if (bitcnt == 0) cur = (rd_src.size() > 0) ? rd_src.pop_front() : 8'hff;
            w_sda_low = !cur[7 - bitcnt];
          end else w_sda_low = 1'b0;
        end
      end
      ps = s; pd = d;
    end
  end

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic go(input logic r, input logic [6:0] dv, input logic [7:0] rg, input logic [3:0] ln);
    @(posedge clock); #1;
    start = 1'b1; rw = r; dev_addr = dv; reg_addr = rg; len = ln;
    @(posedge clock); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clock);
      if (done) break;
    end
    check("done_seen", done, 1);
  endtask

  task automatic check_reset_vals();
    check("rst_scl_oe", scl_oe, 0);   check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);       check("rst_done", done, 0);
    check("rst_wr_ready", wr_ready, 0); check("rst_rd_valid", rd_valid, 0);
    check("rst_nack", nack_err, 0);   check("rst_timeout", timeout_err, 0);
    check("rst_rd_data", rd_data, 0);
  endtask

  initial begin
    int w0, r0, d0;
    reset_n = 1'b1; start = 1'b0; rw = 1'b0; dev_addr = '0; reg_addr = '0; len = '0;
    #2 reset_n = 1'b0;
    #1 check_reset_vals();
    clk_wait(3);
    reset_n = 1'b1;
    clk_wait(2);

    // write 0x68 / reg 0x1A / A5 3C
    tx_q = '{8'hA5, 8'h3C};
    exp_bus = '{1000, 'h0D0, 'h01A, 'h0A5, 'h03C, 1001};
    exp_done.push_back(2'b00);
    w0 = wr_cnt;
    go(1'b0, 7'h68, 8'h1A, 4'd2);
    wait_done(5000);
    clk_wait(2);
    check("wr_count_write", wr_cnt - w0, 2);
    check("nack_write", nack_err, 0);
    check("bus_pending_write", exp_bus.size(), 0);

    // read 0x68 / reg 0x3B / 3 bytes
    rd_src = '{8'h12, 8'h34, 8'h56};
    exp_bus = '{1000, 'h0D0, 'h03B, 1000, 'h0D1, 'h012, 'h034, 'h156, 1001};
    exp_rd = '{8'h12, 8'h34, 8'h56};
    exp_done.push_back(2'b00);
    r0 = rd_cnt;
    go(1'b1, 7'h68, 8'h3B, 4'd3);
    wait_done(5000);
    clk_wait(2);
    check("rd_count_read", rd_cnt - r0, 3);
    check("bus_pending_read", exp_bus.size(), 0);
    check("rd_pending_read", exp_rd.size(), 0);

    // absent device 0x50
    tx_q = '{8'h11, 8'h22};
    exp_bus = '{1000, 'h1A0, 1001};
    exp_done.push_back(2'b10);
    w0 = wr_cnt;
    go(1'b0, 7'h50, 8'h1A, 4'd2);
    wait_done(5000);
    clk_wait(2);
    check("wr_count_nack", wr_cnt - w0, 0);
    check("nack_held", nack_err, 1);
    check("bus_pending_nack", exp_bus.size(), 0);
    tx_q.delete();

    // 40-clock stretch inside the register byte
    st_frame = 1; st_bit = 3; st_len = 40;
    tx_q = '{8'hC3};
    exp_bus = '{1000, 'h0D0, 'h055, 'h0C3, 1001};
    exp_done.push_back(2'b00);
    w0 = wr_cnt;
    go(1'b0, 7'h68, 8'h55, 4'd1);
    check("nack_cleared", nack_err, 0);
    wait_done(5000);
    st_len = 0;
    clk_wait(2);
    check("stretch_timeout", timeout_err, 0);
    check("wr_count_stretch", wr_cnt - w0, 1);
    check("bus_pending_stretch", exp_bus.size(), 0);

    // 300-clock stretch exceeds the limit
    st_frame = 1; st_bit = 3; st_len = 300;
    tx_q = '{8'h99};
    exp_bus = '{1000, 'h0D0};
    exp_done.push_back(2'b01);
    w0 = wr_cnt;
    go(1'b0, 7'h68, 8'h77, 4'd1);
    wait_done(5000);
    st_len = 0;
    check("to_scl_released", scl_oe, 0);
    check("to_sda_released", sda_oe, 0);
    clk_wait(400);
    check("timeout_held", timeout_err, 1);
    check("wr_count_timeout", wr_cnt - w0, 0);
    check("bus_pending_timeout", exp_bus.size(), 0);
    tx_q.delete();

    // read with len=0 goes straight to STOP; start in the done cycle is ignored
    exp_bus = '{1000, 'h0D0, 'h010, 1001};
    exp_done.push_back(2'b00);
    r0 = rd_cnt;
    go(1'b1, 7'h68, 8'h10, 4'd0);
    check("timeout_cleared", timeout_err, 0);
    wait_done(5000);
    start = 1'b1; rw = 1'b0; dev_addr = 7'h68; reg_addr = 8'h01; len = 4'd1;
    @(posedge clock); #1;
    start = 1'b0;
    clk_wait(20);
    check("start_in_done_ignored", busy, 0);
    check("rd_count_len0", rd_cnt - r0, 0);
    check("bus_pending_len0", exp_bus.size(), 0);

    // reset during a read, after the first byte
    rd_src = '{8'h12, 8'h34, 8'h56};
    exp_bus = '{1000, 'h0D0, 'h03B, 1000, 'h0D1};
    exp_rd = '{8'h12};
    r0 = rd_cnt; d0 = done_cnt;
    go(1'b1, 7'h68, 8'h3B, 4'd3);
    for (int k = 0; k < 5000; k++) begin
      @(negedge clock);
      if (rd_valid) break;
    end
    check("rd_valid_before_reset", rd_valid, 1);
    clk_wait(2);
    reset_n = 1'b0;
    abort_req++;
    #1 check_reset_vals();
    rd_src.delete();
    clk_wait(3);
    reset_n = 1'b1;
    clk_wait(5);
    check("no_done_on_reset", done_cnt - d0, 0);
    check("rd_count_reset", rd_cnt - r0, 1);
    check("bus_pending_reset", exp_bus.size(), 0);

    // normal transaction after reset
    tx_q = '{8'h5A};
    exp_bus = '{1000, 'h0D0, 'h02C, 'h05A, 1001};
    exp_done.push_back(2'b00);
    w0 = wr_cnt;
    go(1'b0, 7'h68, 8'h2C, 4'd1);
    wait_done(5000);
    clk_wait(2);
    check("wr_count_after_reset", wr_cnt - w0, 1);
    check("bus_pending_after_reset", exp_bus.size(), 0);
    check("done_pending", exp_done.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
